// File: rtl/vga_sched_pkg.sv
// Shared types and constants for the VGA write scheduler: drain FSM encoding,
// requester ids and the width of one queued {pos, char} entry.
package vga_sched_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StStrobe = 2'd2,
        StGap    = 2'd3
    } drain_state_e;

    typedef enum logic {
        ReqCpu = 1'b0,
        ReqAux = 1'b1
    } req_id_e;

    localparam int unsigned EntryWidth = 32;

endpackage

// File: rtl/vga_char_fifo.sv
// Small synchronous FIFO holding pending VGA character writes as {pos, char}.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module vga_char_fifo
    import vga_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = EntryWidth
) (
    input  logic                       wire_clock,
    input  logic                       wire_reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q;
    logic [PtrW-1:0]  rptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rptr_q];
    assign count   = count_q;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge wire_clock or posedge wire_reset) begin
        if (wire_reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CntW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge wire_clock) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/vga_write_scheduler.sv
// Round-robin arbiter between CPU and auxiliary writers feeding a FIFO that is
// drained onto the VGA character port with a setup/strobe/gap sequence.
module vga_write_scheduler
    import vga_sched_pkg::*;
#(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned STROBE_CYCLES = 1,
    parameter int unsigned GAP_CYCLES    = 2
) (
    input  logic                       wire_clock,
    input  logic                       wire_reset,
    input  logic                       cpu_req,
    input  logic [15:0]                cpu_pos,
    input  logic [15:0]                cpu_char,
    output logic                       cpu_ack,
    input  logic                       aux_req,
    input  logic [15:0]                aux_pos,
    input  logic [15:0]                aux_char,
    output logic                       aux_ack,
    output logic [15:0]                bus_vga_pos,
    output logic [15:0]                bus_vga_char,
    output logic                       videoflag,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       busy
);

    localparam int unsigned MaxCycles =
        (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
    localparam int unsigned CntW = $clog2(MaxCycles + 1);

    drain_state_e          state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    req_id_e               last_grant_q;
    logic [15:0]           pos_q;
    logic [15:0]           char_q;
    logic                  videoflag_q;

    logic                  pop;
    logic                  space;
    logic                  push;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [EntryWidth-1:0] push_data;
    logic [EntryWidth-1:0] head_data;

    // Popping frees a slot in the same cycle, so a full FIFO can still accept.
    assign space     = !fifo_full || pop;
    assign cpu_ack   = space && cpu_req && (!aux_req || (last_grant_q == ReqAux));
    assign aux_ack   = space && aux_req && (!cpu_req || (last_grant_q == ReqCpu));
    assign push      = cpu_ack || aux_ack;
    assign push_data = cpu_ack ? {cpu_pos, cpu_char} : {aux_pos, aux_char};

    vga_char_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EntryWidth)
    ) u_fifo (
        .wire_clock (wire_clock),
        .wire_reset (wire_reset),
        .push       (push),
        .wdata      (push_data),
        .pop        (pop),
        .rdata      (head_data),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                state_d = StStrobe;
                cnt_d   = CntW'(STROBE_CYCLES - 1);
            end
            StStrobe: begin
                if (cnt_q == '0) begin
                    state_d = StGap;
                    cnt_d   = CntW'(GAP_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StGap: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wire_clock or posedge wire_reset) begin
        if (wire_reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            last_grant_q <= ReqAux;
            pos_q        <= '0;
            char_q       <= '0;
            videoflag_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            videoflag_q <= (state_d == StStrobe);
            if (cpu_ack) begin
                last_grant_q <= ReqCpu;
            end else if (aux_ack) begin
                last_grant_q <= ReqAux;
            end
            // Bus data only changes on the IDLE-to-SETUP edge.
            if (pop) begin
                pos_q  <= head_data[31:16];
                char_q <= head_data[15:0];
            end
        end
    end

    assign bus_vga_pos  = pos_q;
    assign bus_vga_char = char_q;
    assign videoflag    = videoflag_q;
    assign busy         = (fifo_count != '0) || (state_q != StIdle);

endmodule

// File: doc/vga_write_scheduler.md
Name: vga_write_scheduler

Overview:
- Shares the single VGA character-write port (bus_vga_pos, bus_vga_char, videoflag) between two requesters: the CPU outchar path and an auxiliary writer (keyboard echo, screen clear).
- Accepts requests by round-robin arbitration into a small FIFO. Drains that FIFO to the VGA port with a fixed setup/strobe/gap sequence.
- The CPU no longer hand-times videoflag pulses; it only waits for ack.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- STROBE_CYCLES, 1, cycles videoflag is held high per character; at least 1.
- GAP_CYCLES, 2, cycles videoflag is held low after a strobe, with data still held; at least 1.

Ports:
- wire_clock  in  1  system clock; all state changes on the rising edge.
- wire_reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU write request; held high with stable data until cpu_ack.
- cpu_pos  in  16  CPU screen position.
- cpu_char  in  16  CPU character/colour word.
- cpu_ack  out  1  combinational; high in the cycle the CPU entry is written.
- aux_req  in  1  auxiliary request; same rules as cpu_req.
- aux_pos  in  16  auxiliary position.
- aux_char  in  16  auxiliary character word.
- aux_ack  out  1  combinational; high in the cycle the auxiliary entry is written.
- bus_vga_pos  out  16  registered position to VGA.
- bus_vga_char  out  16  registered character to VGA.
- videoflag  out  1  registered write strobe to VGA.
- fifo_count  out  clog2(DEPTH+1)  number of occupied entries.
- busy  out  1  high when fifo_count != 0 or the drain FSM is not IDLE.

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - FIFO pointers and count go to 0; stored entries are discarded.
  - FSM goes to IDLE; videoflag, bus_vga_pos and bus_vga_char go to 0.
  - Round-robin pointer resets to last_grant = AUX, so the CPU wins the first tie.
- Space: space = (fifo_count < DEPTH) or pop_this_cycle. A push into a full FIFO is legal in the same cycle as a pop.
- Arbitration (combinational, at most one push per cycle):
  - Only one requester high and space: grant it.
  - Both high and space: grant the requester that is not last_grant.
  - No space: no ack; requests wait with data held.
- Push: on the rising edge where an ack is high, write {pos, char} at wptr. wptr wraps modulo DEPTH. last_grant updates to the granted requester.
- Requester protocol: after ack, the requester drops req or presents new data in the next cycle. Back-to-back acks to one requester are allowed when the other is idle.
- Count: +1 on push, -1 on pop, unchanged on simultaneous push and pop. It never exceeds DEPTH and never underflows.
- Drain FSM states: IDLE, SETUP, STROBE, GAP.
  - IDLE: if fifo_count != 0, pop the head into bus_vga_pos/bus_vga_char and go to SETUP. An entry pushed at edge N is popped no earlier than edge N+1.
  - SETUP: one cycle, videoflag 0, data stable. Go to STROBE with videoflag set to 1.
  - STROBE: videoflag stays 1 for exactly STROBE_CYCLES cycles, then go to GAP with videoflag 0.
  - GAP: data held for GAP_CYCLES cycles, then go to IDLE.
- Throughput: one character per 2+STROBE_CYCLES+GAP_CYCLES cycles; defaults give 5.
- Data stability: bus_vga_pos/bus_vga_char change only on the IDLE-to-SETUP edge, so they are stable for the whole strobe. Both hold their last value when idle.
- Timing example, empty FIFO, defaults: ack at edge N, data on bus after N+1, videoflag high after N+2, low after N+3, IDLE at N+5.
- Cycle counter: a single down-counter, width clog2(max(STROBE_CYCLES, GAP_CYCLES)+1), reloaded on each state entry.

Decomposition:
- Package vga_sched_pkg holds:
  - FSM state encoding: IDLE=2'd0, SETUP=2'd1, STROBE=2'd2, GAP=2'd3.
  - Requester ids: CPU=1'b0, AUX=1'b1.
  - Entry width constant: 32 bits ({pos, char}).
- One sub-module, vga_char_fifo: parameterised DEPTH × 32-bit synchronous FIFO with async reset, push/pop, count, full/empty.
- Arbiter and drain FSM live in the top module.

Test Plan:
- Single CPU write of pos 16'h0205, char 16'h0041 into an empty FIFO: cpu_ack high 1 cycle; bus shows 0205/0041 one cycle later; videoflag high for exactly 1 cycle; busy drops 5 cycles after the ack.
- cpu_req and aux_req both held high, 3 entries each: acks alternate CPU, AUX, CPU, AUX, CPU, AUX; the VGA sequence matches that order.
- aux_req held with no drain progress until fifo_count=4: aux_ack stays low. On the pop edge a push completes in the same cycle and fifo_count stays 4.
- STROBE_CYCLES=3, GAP_CYCLES=1: videoflag high exactly 3 cycles per character; character period 6 cycles; data unchanged for all 3 strobe cycles.
- Assert wire_reset during STROBE with 2 entries queued: videoflag, bus outputs and fifo_count go to 0 immediately, without waiting for a clock. After release, no stale character is written.
- 10 CPU writes with DEPTH=4 to exercise pointer wrap: the VGA output order equals the input order, with no loss or duplication.
